// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_pkg                                                     |
// | Description : Shared definitions for the 7-segment scan decoder.           |
// |               SEG_* are active-low scan-bus patterns {a..g,dp}, dp off.    |
// |               seg7_to_hex maps active-low a..g to {err,nibble}.            |
// |               state_t encodes the frame hand-off FSM.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Returns {err, nibble}; any pattern outside the table (including blank)
  // yields err=1 with nibble 0. The dp bit is not part of the match.
  function automatic logic [4:0] seg7_to_hex(input logic [6:0] i_seg_n);
    logic [4:0] w_r;
    case (i_seg_n)
      SEG_0[7:1]: w_r = 5'h00;
      SEG_1[7:1]: w_r = 5'h01;
      SEG_2[7:1]: w_r = 5'h02;
      SEG_3[7:1]: w_r = 5'h03;
      SEG_4[7:1]: w_r = 5'h04;
      SEG_5[7:1]: w_r = 5'h05;
      SEG_6[7:1]: w_r = 5'h06;
      SEG_7[7:1]: w_r = 5'h07;
      SEG_8[7:1]: w_r = 5'h08;
      SEG_9[7:1]: w_r = 5'h09;
      SEG_A[7:1]: w_r = 5'h0A;
      SEG_B[7:1]: w_r = 5'h0B;
      SEG_C[7:1]: w_r = 5'h0C;
      SEG_D[7:1]: w_r = 5'h0D;
      SEG_E[7:1]: w_r = 5'h0E;
      SEG_F[7:1]: w_r = 5'h0F;
      default:    w_r = 5'h10;
    endcase
    return w_r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_track.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_digit_track                                             |
// | Description : Stability tracker for one scanned digit. Remembers the last  |
// |               qualified pattern and how many consecutive times it was seen.|
// |               Pulses o_accept on the sample that brings the count to       |
// |               STABLE; the count then saturates until the pattern changes.  |
// | Ports       : clk, rst        clock / async active-high reset              |
// |               i_sample        qualified sample for this digit this cycle   |
// |               i_pattern[7:0]  raw active-low segment pattern               |
// |               o_accept        one-cycle accept pulse                       |
// |               o_pattern[7:0]  last pattern held by the tracker             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_digit_track
  import seg7_pkg::*;
#(
  parameter int STABLE = 8,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sample,
  input  logic [7:0] i_pattern,
  output logic       o_accept,
  output logic [7:0] o_pattern
);

  localparam logic [CW-1:0] C_STABLE = CW'(STABLE);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  logic [7:0]    r_p;
  logic [CW-1:0] r_c;
  logic          w_same;

  assign w_same    = (i_pattern == r_p);
  // Accept only on the STABLE-1 -> STABLE step, so a saturated digit never re-fires.
  assign o_accept  = i_sample && w_same && (r_c == (C_STABLE - C_ONE));
  assign o_pattern = r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= 8'h00;
      r_c <= '0;
    end else if (i_sample) begin
      if (w_same) begin
        if (r_c != C_STABLE) begin
          r_c <= r_c + C_ONE;
        end
      end else begin
        r_p <= i_pattern;
        r_c <= C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_decoder                                            |
// | Description : Watches an active-low multiplexed 7-seg scan bus, debounces  |
// |               each digit, decodes it back to hex and emits whole frames on |
// |               a valid/ready port.                                          |
// | Ports       : clk, rst              clock / async active-high reset        |
// |               i_seg[7:0]            active-low {a,b,c,d,e,f,g,dp}          |
// |               i_an[NDIG-1:0]        active-low digit enables               |
// |               i_out_ready           consumer ready                         |
// |               o_out_valid           frame available                        |
// |               o_out_hex[4*NDIG-1:0] digit i in [4i+3:4i]                   |
// |               o_out_dp[NDIG-1:0]    decimal points, 1 = lit                |
// |               o_out_err[NDIG-1:0]   pattern not in hex table               |
// |               o_overrun             sticky frame-dropped flag              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 8,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_seg,
  input  logic [NDIG-1:0]   i_an,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [4*NDIG-1:0] o_out_hex,
  output logic [NDIG-1:0]   o_out_dp,
  output logic [NDIG-1:0]   o_out_err,
  output logic              o_overrun
);

  logic [NDIG-1:0]   w_an_act;
  logic              w_one_hot;
  logic [NDIG-1:0]   w_qual;
  logic [NDIG-1:0]   w_accept;
  logic [7:0]        w_pat [NDIG];
  logic [7:0]        w_acc_pat;
  logic [4:0]        w_dec;

  logic [4*NDIG-1:0] r_buf_hex, w_buf_hex_next;
  logic [NDIG-1:0]   r_buf_dp,  w_buf_dp_next;
  logic [NDIG-1:0]   r_buf_err, w_buf_err_next;
  logic [NDIG-1:0]   r_seen,    w_seen_next;
  logic              w_full;

  state_t            r_state, w_state_next;
  logic              w_load, w_clear_valid, w_set_overrun;

  logic              r_out_valid;
  logic [4*NDIG-1:0] r_out_hex;
  logic [NDIG-1:0]   r_out_dp;
  logic [NDIG-1:0]   r_out_err;
  logic              r_overrun;

  // A sample is valid only when exactly one enable is active.
  assign w_an_act  = ~i_an;
  assign w_one_hot = (w_an_act != '0) && ((w_an_act & (w_an_act - 1'b1)) == '0);
  assign w_qual    = w_one_hot ? w_an_act : '0;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_track
      seg7_digit_track #(
        .STABLE (STABLE),
        .CW     (CW)
      ) u_track (
        .clk       (clk),
        .rst       (rst),
        .i_sample  (w_qual[gi]),
        .i_pattern (i_seg),
        .o_accept  (w_accept[gi]),
        .o_pattern (w_pat[gi])
      );
    end
  endgenerate

  // At most one digit accepts per cycle, so an OR-mux picks its pattern.
  always_comb begin
    w_acc_pat = 8'h00;
    for (int k = 0; k < NDIG; k++) begin
      w_acc_pat = w_acc_pat | (w_accept[k] ? w_pat[k] : 8'h00);
    end
  end

  assign w_dec = seg7_to_hex(w_acc_pat[7:1]);

  always_comb begin
    w_buf_hex_next = r_buf_hex;
    w_buf_dp_next  = r_buf_dp;
    w_buf_err_next = r_buf_err;
    for (int k = 0; k < NDIG; k++) begin
      if (w_accept[k]) begin
        w_buf_hex_next[4*k +: 4] = w_dec[3:0];
        w_buf_dp_next[k]         = ~w_acc_pat[0];
        w_buf_err_next[k]        = w_dec[4];
      end
    end
  end

  // The final latch of a frame counts towards completion in the same cycle.
  assign w_seen_next = r_seen | w_accept;
  assign w_full      = &w_seen_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_clear_valid = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_full) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_out_ready) begin
          // Hand-off and completion together: new frame replaces the accepted one.
          if (w_full) begin
            w_load = 1'b1;
          end else begin
            w_clear_valid = 1'b1;
            w_state_next  = COLLECT;
          end
        end else if (w_full) begin
          w_set_overrun = 1'b1;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_hex   <= '0;
      r_buf_dp    <= '0;
      r_buf_err   <= '0;
      r_seen      <= '0;
      r_out_valid <= 1'b0;
      r_out_hex   <= '0;
      r_out_dp    <= '0;
      r_out_err   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_buf_hex <= w_buf_hex_next;
      r_buf_dp  <= w_buf_dp_next;
      r_buf_err <= w_buf_err_next;
      // A completed frame always clears the mask, whether loaded or dropped.
      r_seen    <= w_full ? '0 : w_seen_next;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_hex   <= w_buf_hex_next;
        r_out_dp    <= w_buf_dp_next;
        r_out_err   <= w_buf_err_next;
      end else if (w_clear_valid) begin
        r_out_valid <= 1'b0;
      end
      if (w_set_overrun) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_hex   = r_out_hex;
  assign o_out_dp    = r_out_dp;
  assign o_out_err   = r_out_err;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_decoder                                         |
// | Description : Self-checking bench for seg7_scan_decoder (NDIG=4,STABLE=8). |
// |               Expected frames are queued as stimulus is driven and popped  |
// |               by a monitor at each handshake.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 8;
  localparam int CW     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_seg;
  logic [3:0]  i_an;
  logic        i_out_ready;
  logic        o_out_valid;
  logic [15:0] o_out_hex;
  logic [3:0]  o_out_dp;
  logic [3:0]  o_out_err;
  logic        o_overrun;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NDIG   (NDIG),
    .STABLE (STABLE),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_seg       (i_seg),
    .i_an        (i_an),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_hex   (o_out_hex),
    .o_out_dp    (o_out_dp),
    .o_out_err   (o_out_err),
    .o_overrun   (o_overrun)
  );

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  typedef struct packed {
    logic [3:0][7:0] pats;
    logic            inter;
    logic [1:0]      reps;
    frame_t          exp;
  } vec_t;

  frame_t exp_q[$];
  frame_t mon_e;
  vec_t   vecs[5];
  int     n_checks     = 0;
  int     n_fail       = 0;
  int     frame_cnt    = 0;
  int     valid_cycles = 0;
  int     fc0;

  localparam logic [7:0] BLANK   = 8'hFF;
  localparam logic [7:0] BADPAT  = 8'hAB;
  localparam logic [7:0] DISRUPT = 8'h55;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Independent lit-segment table (active-high a..g), converted to bus polarity.
  function automatic logic [7:0] segp(input logic [3:0] v, input logic dp);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'b1111110;  4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;  4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;  4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;  4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;  4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;  4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;  4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;  4'hF: lit = 7'b1000111;
      default: lit = 7'b0000000;
    endcase
    return {~lit, ~dp};
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic drive(input logic [7:0] s, input logic [3:0] a);
    i_seg = s;
    i_an  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic scan_digit(input int d, input logic [7:0] s, input int n);
    repeat (n) drive(s, an_of(d));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(BLANK, 4'hF);
  endtask

  // One odd sample per digit restarts every tracker so the next run is fresh.
  task automatic disrupt();
    for (int d = 0; d < 4; d++) drive(DISRUPT, an_of(d));
  endtask

  task automatic scan(input logic [3:0][7:0] p, input logic inter, input int reps);
    for (int r = 0; r < reps; r++) begin
      if (inter) begin
        for (int c = 0; c < STABLE; c++)
          for (int d = 0; d < 4; d++) drive(p[d], an_of(d));
      end else begin
        for (int d = 0; d < 4; d++) scan_digit(d, p[d], STABLE);
      end
    end
  endtask

  // Scoreboard monitor: a frame is consumed when valid && ready before an edge.
  always @(negedge clk) begin
    if (!rst && o_out_valid) valid_cycles++;
    if (!rst && o_out_valid && i_out_ready) begin
      frame_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected frame", 32'(o_out_hex), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame hex", 32'(o_out_hex), 32'(mon_e.hex));
        check("frame dp",  32'(o_out_dp),  32'(mon_e.dp));
        check("frame err", 32'(o_out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][7:0] p;

    vecs[0] = '{pats: {segp(4'h4,1'b0), segp(4'h3,1'b0), segp(4'h2,1'b0), segp(4'h1,1'b0)},
                inter: 1'b0, reps: 2'd2, exp: '{hex: 16'h4321, dp: 4'b0000, err: 4'b0000}};
    vecs[1] = '{pats: {segp(4'hD,1'b0), segp(4'hC,1'b0), segp(4'hB,1'b0), segp(4'hA,1'b0)},
                inter: 1'b1, reps: 2'd1, exp: '{hex: 16'hDCBA, dp: 4'b0000, err: 4'b0000}};
    vecs[2] = '{pats: {segp(4'hF,1'b0), BLANK, segp(4'h9,1'b1), segp(4'h7,1'b0)},
                inter: 1'b0, reps: 2'd1, exp: '{hex: 16'hF097, dp: 4'b0010, err: 4'b0100}};
    vecs[3] = '{pats: {segp(4'hF,1'b1), segp(4'h6,1'b1), segp(4'h0,1'b1), segp(4'h8,1'b1)},
                inter: 1'b1, reps: 2'd1, exp: '{hex: 16'hF608, dp: 4'b1111, err: 4'b0000}};
    vecs[4] = '{pats: {segp(4'hC,1'b0), segp(4'hE,1'b1), segp(4'h5,1'b0), BADPAT},
                inter: 1'b0, reps: 2'd1, exp: '{hex: 16'hCE50, dp: 4'b0100, err: 4'b0001}};

    rst         = 1'b1;
    i_seg       = BLANK;
    i_an        = 4'hF;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid",   32'(o_out_valid), 32'd0);
    check("reset hex",     32'(o_out_hex),   32'd0);
    check("reset dp",      32'(o_out_dp),    32'd0);
    check("reset err",     32'(o_out_err),   32'd0);
    check("reset overrun", 32'(o_overrun),   32'd0);
    rst = 1'b0;
    idle(2);

    // Table rows: basic frames, interleaved scan, blank/dp, all dp, bad pattern.
    for (int i = 0; i < 5; i++) begin
      disrupt();
      exp_q.push_back(vecs[i].exp);
      fc0          = frame_cnt;
      valid_cycles = 0;
      scan(vecs[i].pats, vecs[i].inter, int'(vecs[i].reps));
      idle(3);
      check($sformatf("row%0d frame count", i), 32'(frame_cnt - fc0), 32'd1);
      check($sformatf("row%0d valid width", i), 32'(valid_cycles), 32'd1);
    end

    // Malformed enables mid-scan must not touch any tracker.
    disrupt();
    p = {segp(4'h7,1'b0), segp(4'h2,1'b0), segp(4'h0,1'b0), segp(4'hC,1'b0)};
    exp_q.push_back('{hex: 16'h720C, dp: 4'b0000, err: 4'b0000});
    fc0 = frame_cnt;
    scan_digit(0, p[0], STABLE);
    scan_digit(1, p[1], STABLE);
    scan_digit(2, p[2], 4);
    for (int j = 0; j < 10; j++) begin
      drive(p[2], 4'b1100);
      drive(p[2], 4'b1111);
    end
    scan_digit(3, p[3], STABLE);
    scan_digit(2, p[2], 3);
    idle(2);
    check("bad-an no early frame", 32'(frame_cnt - fc0), 32'd0);
    scan_digit(2, p[2], 1);
    idle(2);
    check("bad-an frame count", 32'(frame_cnt - fc0), 32'd1);

    // Glitch on digit 0 restarts its stability run.
    disrupt();
    p = {segp(4'h3,1'b0), segp(4'hA,1'b0), segp(4'h1,1'b0), segp(4'h6,1'b0)};
    exp_q.push_back('{hex: 16'h3A16, dp: 4'b0000, err: 4'b0000});
    fc0 = frame_cnt;
    scan_digit(0, segp(4'h5,1'b0), 7);
    scan_digit(0, p[0], 1);
    scan_digit(0, p[0], STABLE);
    for (int d = 1; d < 4; d++) scan_digit(d, p[d], STABLE);
    idle(3);
    check("glitch frame count", 32'(frame_cnt - fc0), 32'd1);

    // Hand-off and completion on the same edge: both frames delivered, no overrun.
    i_out_ready = 1'b0;
    disrupt();
    fc0 = frame_cnt;
    exp_q.push_back('{hex: 16'h3210, dp: 4'b0000, err: 4'b0000});
    scan({segp(4'h3,1'b0), segp(4'h2,1'b0), segp(4'h1,1'b0), segp(4'h0,1'b0)}, 1'b0, 1);
    idle(2);
    check("simul first held valid", 32'(o_out_valid), 32'd1);
    p = {segp(4'h7,1'b0), segp(4'h6,1'b0), segp(4'h5,1'b0), segp(4'h4,1'b0)};
    exp_q.push_back('{hex: 16'h7654, dp: 4'b0000, err: 4'b0000});
    for (int d = 0; d < 3; d++) scan_digit(d, p[d], STABLE);
    scan_digit(3, p[3], STABLE - 1);
    i_out_ready = 1'b1;
    drive(p[3], an_of(3));
    check("simul valid stays", 32'(o_out_valid), 32'd1);
    check("simul new frame hex", 32'(o_out_hex), 32'h7654);
    idle(3);
    check("simul frame count", 32'(frame_cnt - fc0), 32'd2);
    check("simul no overrun", 32'(o_overrun), 32'd0);

    // Consumer stalls across two frames: first held, second dropped, overrun set.
    i_out_ready = 1'b0;
    disrupt();
    fc0 = frame_cnt;
    exp_q.push_back('{hex: 16'h6789, dp: 4'b0000, err: 4'b0000});
    scan({segp(4'h6,1'b0), segp(4'h7,1'b0), segp(4'h8,1'b0), segp(4'h9,1'b0)}, 1'b0, 1);
    idle(2);
    check("stall valid", 32'(o_out_valid), 32'd1);
    check("stall overrun clear", 32'(o_overrun), 32'd0);
    scan({segp(4'hF,1'b0), segp(4'hE,1'b0), segp(4'hD,1'b0), segp(4'hB,1'b0)}, 1'b1, 1);
    idle(2);
    check("stall held hex", 32'(o_out_hex), 32'h6789);
    check("stall still valid", 32'(o_out_valid), 32'd1);
    check("stall overrun", 32'(o_overrun), 32'd1);
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall valid drop", 32'(o_out_valid), 32'd0);
    check("stall overrun sticky", 32'(o_overrun), 32'd1);
    check("stall frame count", 32'(frame_cnt - fc0), 32'd1);

    // Reset after three digits discards them; frame needs all four again.
    disrupt();
    p = {segp(4'h9,1'b0), segp(4'h5,1'b0), segp(4'h3,1'b0), segp(4'h1,1'b0)};
    for (int d = 0; d < 3; d++) scan_digit(d, p[d], STABLE);
    rst = 1'b1;
    #2;
    check("midrst valid", 32'(o_out_valid), 32'd0);
    check("midrst overrun", 32'(o_overrun), 32'd0);
    check("midrst hex", 32'(o_out_hex), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fc0 = frame_cnt;
    scan_digit(3, p[3], STABLE);
    idle(3);
    check("midrst no frame", 32'(frame_cnt - fc0), 32'd0);
    exp_q.push_back('{hex: 16'h9531, dp: 4'b0000, err: 4'b0000});
    for (int d = 0; d < 3; d++) scan_digit(d, p[d], STABLE);
    idle(3);
    check("midrst frame count", 32'(frame_cnt - fc0), 32'd1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
